// File: rtl/alu_pkg.sv
// Shared definitions for the 6-bit ALU datapath blocks.
//   WIDTH_DEF   : default operand/result width (two's complement)
//   CNT_W       : width of an iteration counter that counts 0..WIDTH_DEF-1
//   MIN_NEG     : most negative value at WIDTH_DEF (1 followed by zeros)
//   div_state_t : sequencing states of the signed divider
package alu_pkg;

    localparam int WIDTH_DEF = 6;
    localparam int CNT_W     = $clog2(WIDTH_DEF);

    localparam logic [WIDTH_DEF-1:0] MIN_NEG = {1'b1, {(WIDTH_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/signed_abs_neg.sv
// Combinational magnitude / conditional-negate helper.
//   value    : input operand
//   abs_mode : 1 -> return |value| (negate when value is negative)
//              0 -> return -value when neg is set, else value
//   neg      : negate request, used only when abs_mode = 0
//   result   : magnitude or negation, wrapping modulo 2^W.
//              |MIN_NEG| comes out as MIN_NEG, which is the correct
//              magnitude when the result is read as unsigned.
module signed_abs_neg #(
    parameter int W = 6
) (
    input  logic [W-1:0] value,
    input  logic         abs_mode,
    input  logic         neg,
    output logic [W-1:0] result
);

    logic do_negate;

    assign do_negate = abs_mode ? value[W-1] : neg;
    assign result    = do_negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/six_bit_signed_divider.sv
// Sequential signed divider: restoring division on magnitudes, one
// quotient bit per cycle, followed by a single sign-correction cycle.
//   clk, rst    : clock, asynchronous active-high reset
//   in_valid    : operand pair presented      in_ready  : high in IDLE only
//   dividend    : signed dividend             divisor   : signed divisor
//   out_valid   : result presented            out_ready : consumer accepts
//   quotient    : truncated toward zero       remainder : sign of dividend
//   div_by_zero : divisor was zero            overflow  : MIN_NEG / -1
// Accept-to-result is WIDTH+2 edges counting the accept edge itself
// (WIDTH RUN edges, one FIX edge); divide-by-zero skips straight to DONE.
module six_bit_signed_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int                 CW       = $clog2(WIDTH);
    localparam logic [WIDTH-1:0]   MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]      LAST_IT  = CW'(WIDTH - 1);

    div_state_t state_reg, state_next;

    logic [CW-1:0]    cnt_reg;
    logic             neg_q_reg, neg_r_reg;
    logic [WIDTH-1:0] quo_reg;      // dividend magnitude, quotient bits shift in
    logic [WIDTH-1:0] mag_b_reg;    // divisor magnitude
    logic [WIDTH:0]   rem_reg;      // partial remainder
    logic [WIDTH-1:0] quotient_reg, remainder_reg;
    logic             dbz_reg, ovf_reg;

    logic accept;
    logic divisor_zero;
    logic [WIDTH-1:0] mag_a, mag_b, quo_fixed, rem_fixed;
    logic [WIDTH+1:0] rem_shift, trial;

    assign accept       = (state_reg == IDLE) && in_valid;
    assign divisor_zero = (divisor == '0);

    signed_abs_neg #(.W(WIDTH)) u_abs_dividend (
        .value(dividend), .abs_mode(1'b1), .neg(1'b0), .result(mag_a));
    signed_abs_neg #(.W(WIDTH)) u_abs_divisor (
        .value(divisor),  .abs_mode(1'b1), .neg(1'b0), .result(mag_b));
    signed_abs_neg #(.W(WIDTH)) u_fix_quo (
        .value(quo_reg), .abs_mode(1'b0), .neg(neg_q_reg), .result(quo_fixed));
    signed_abs_neg #(.W(WIDTH)) u_fix_rem (
        .value(rem_reg[WIDTH-1:0]), .abs_mode(1'b0), .neg(neg_r_reg),
        .result(rem_fixed));

    // Shift the next dividend bit into the partial remainder, then trial
    // subtract. Two spare bits keep the borrow visible in trial's MSB.
    assign rem_shift = {rem_reg, quo_reg[WIDTH-1]};
    assign trial     = rem_shift - {2'b00, mag_b_reg};

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: if (in_valid)               state_next = divisor_zero ? DONE : RUN;
            RUN:  if (cnt_reg == LAST_IT)     state_next = FIX;
            FIX:                              state_next = DONE;
            DONE: if (out_ready)              state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg       <= '0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            quo_reg       <= '0;
            mag_b_reg     <= '0;
            rem_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            if (accept) begin
                neg_q_reg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                neg_r_reg <= dividend[WIDTH-1];
                quo_reg   <= mag_a;
                mag_b_reg <= mag_b;
                rem_reg   <= '0;
                cnt_reg   <= '0;
                dbz_reg   <= divisor_zero;
                ovf_reg   <= (dividend == MOST_NEG) && (divisor == '1);
                if (divisor_zero) begin
                    quotient_reg  <= '1;
                    remainder_reg <= dividend;
                end
            end else if (state_reg == RUN) begin
                cnt_reg <= cnt_reg + CW'(1);
                if (!trial[WIDTH+1]) begin
                    rem_reg <= trial[WIDTH:0];
                    quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
                end else begin
                    rem_reg <= rem_shift[WIDTH:0];
                    quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
                end
            end else if (state_reg == FIX) begin
                quotient_reg  <= quo_fixed;
                remainder_reg <= rem_fixed;
            end
        end
    end

    assign in_ready    = (state_reg == IDLE);
    assign out_valid   = (state_reg == DONE);
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;
    assign overflow    = ovf_reg;

endmodule

// File: tb/tb_six_bit_signed_divider.sv
module tb_six_bit_signed_divider;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] dividend = '0;
    logic [5:0] divisor = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [5:0] quotient;
    logic [5:0] remainder;
    logic       div_by_zero;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    six_bit_signed_divider dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    // Present operands for one accept edge; returns after that edge (#1).
    task automatic present(input logic [5:0] a, input logic [5:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 6'bxxxxxx;
        divisor  = 6'bxxxxxx;
    endtask

    // One full transaction: accept, wait for result, check latency (edges
    // counted including the accept edge), result fields, then consume.
    task automatic run_div(input string name, input logic [5:0] a, input logic [5:0] b,
                           input int exp_lat, input logic [5:0] exp_q,
                           input logic [5:0] exp_r, input logic exp_dbz,
                           input logic exp_ovf);
        int n;
        present(a, b);
        n = 1;
        while (!out_valid && n < 20) begin
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL %s busy_in_ready edge=%0d got=%b want=0", name, n, in_ready);
            end
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (n !== exp_lat || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s latency got=%0d want=%0d out_valid=%b", name, n, exp_lat, out_valid);
        end
        total++;
        if (quotient !== exp_q || remainder !== exp_r ||
            div_by_zero !== exp_dbz || overflow !== exp_ovf) begin
            bad++;
            $display("FAIL %s result got q=%b r=%b dbz=%b ovf=%b want q=%b r=%b dbz=%b ovf=%b",
                     name, quotient, remainder, div_by_zero, overflow,
                     exp_q, exp_r, exp_dbz, exp_ovf);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s consume got out_valid=%b in_ready=%b want 0/1",
                     name, out_valid, in_ready);
        end
        $display("txn %s: %b / %b -> q=%b r=%b dbz=%b ovf=%b lat=%0d",
                 name, a, b, quotient, remainder, div_by_zero, overflow, n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 6'b0 ||
            remainder !== 6'b0 || div_by_zero !== 1'b0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset got in_ready=%b out_valid=%b q=%b r=%b dbz=%b ovf=%b want 1 0 0 0 0 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("txn reset: in_ready=%b out_valid=%b", in_ready, out_valid);
    endtask

    task automatic test_basic();
        run_div("20/3", 6'd20, 6'd3, 8, 6'b000110, 6'b000010, 1'b0, 1'b0);
    endtask

    task automatic test_signs();
        run_div("-20/3", 6'b101100, 6'b000011, 8, 6'b111010, 6'b111110, 1'b0, 1'b0);
        run_div("20/-3", 6'b010100, 6'b111101, 8, 6'b111010, 6'b000010, 1'b0, 1'b0);
        run_div("-7/-2", 6'b111001, 6'b111110, 8, 6'b000011, 6'b111111, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        run_div("-32/-1", 6'b100000, 6'b111111, 8, 6'b100000, 6'b000000, 1'b0, 1'b1);
        run_div("-32/1",  6'b100000, 6'b000001, 8, 6'b100000, 6'b000000, 1'b0, 1'b0);
        run_div("31/-32", 6'b011111, 6'b100000, 8, 6'b000000, 6'b011111, 1'b0, 1'b0);
    endtask

    task automatic test_div_zero();
        run_div("7/0", 6'b000111, 6'b000000, 1, 6'b111111, 6'b000111, 1'b1, 1'b0);
        // flags must clear on the next accept
        run_div("5/5", 6'd5, 6'd5, 8, 6'b000001, 6'b000000, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        int n;
        present(6'd21, 6'd5);
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (n !== 8) begin
            bad++;
            $display("FAIL bp_latency got=%0d want=8", n);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                quotient !== 6'd4 || remainder !== 6'd1) begin
                bad++;
                $display("FAIL bp_hold cycle=%0d got ov=%b ir=%b q=%b r=%b want 1 0 000100 000001",
                         i, out_valid, in_ready, quotient, remainder);
            end
        end
        // consume while in_valid is high: that edge must not accept
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        dividend  = 6'd9;
        divisor   = 6'd2;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_consume got ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
        // next edge accepts 9/2 -> 4 r 1
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (n !== 8 || quotient !== 6'd4 || remainder !== 6'd1) begin
            bad++;
            $display("FAIL bp_next got lat=%0d q=%b r=%b want 8 000100 000001", n, quotient, remainder);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        $display("txn backpressure: 21/5 held, then 9/2 -> q=%b r=%b", quotient, remainder);
    endtask

    task automatic test_reset_mid_run();
        present(6'd31, 6'd2);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 6'b0 || remainder !== 6'b0) begin
            bad++;
            $display("FAIL reset_mid_run got ov=%b ir=%b q=%b r=%b want 0 1 0 0",
                     out_valid, in_ready, quotient, remainder);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("txn reset_mid_run: ov=%b ir=%b", out_valid, in_ready);
        run_div("9/4", 6'd9, 6'd4, 8, 6'b000010, 6'b000001, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_overflow();
        test_div_zero();
        test_backpressure();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1);
    end

endmodule
